// File: rtl/decoder_grant_arbiter_if.sv
// rtl/decoder_grant_arbiter_if.sv - requester bank and decoder select bundle for decoder_grant_arbiter
interface decoder_grant_arbiter_if;
  logic [7:0] Req;
  logic       Enable;
  logic       A;
  logic       B;
  logic       C;
  logic       Busy;
  logic       Timeout;

  modport master (output Req, input Enable, A, B, C, Busy, Timeout);
  modport slave  (input Req, output Enable, A, B, C, Busy, Timeout);
endinterface

// File: rtl/decoder_grant_arbiter.sv
// rtl/decoder_grant_arbiter.sv - round-robin arbiter driving a 3-to-8 decoder select
// Optional hold limit enabled by DECODER_ARB_TIMEOUT_EN.
module decoder_grant_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  decoder_grant_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic       tmo_q, tmo_d;
  logic [2:0] pick;
  logic       pick_valid;

  // Legal range is 1..256; an empty block names the violation in elaboration output.
  if (MAX_HOLD < 1 || MAX_HOLD > 256) begin : g_max_hold_out_of_range
  end

`ifdef DECODER_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  // Scan ptr+1 .. ptr+8 so the last grantee is considered last.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!pick_valid && bus.Req[ptr_q + 3'(k)]) begin
        pick_valid = 1'b1;
        pick       = ptr_q + 3'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    tmo_d   = 1'b0;
`ifdef DECODER_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          idx_d   = pick;
          state_d = GRANT;
`ifdef DECODER_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (!bus.Req[idx_q]) begin
          ptr_d   = idx_q;
          state_d = GAP;
        end
`ifdef DECODER_ARB_TIMEOUT_EN
        else if (cnt_q == HOLD_LAST) begin
          ptr_d   = idx_q;
          tmo_d   = 1'b1;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    en_d   = (state_d == GRANT);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      ptr_q   <= 3'd7;
      idx_q   <= 3'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
`ifdef DECODER_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
`ifdef DECODER_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.Enable  = en_q;
  assign bus.A       = idx_q[2];
  assign bus.B       = idx_q[1];
  assign bus.C       = idx_q[0];
  assign bus.Busy    = busy_q;
  assign bus.Timeout = tmo_q;

endmodule

// File: doc/decoder_grant_arbiter.md
# decoder_grant_arbiter

Round-robin arbiter that shares one 3-to-8 line decoder among eight requesters. It drives the decoder's `Enable`, `A`, `B` and `C` inputs so that decoder output `F[i]` is the one-hot grant to requester `i`. Grants are registered, held until the requester releases (or until an optional hold timeout), and separated by a fixed dead time. It sits between the requester bank and the `Line_Decoder` instance.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles when the timeout is compiled in. Legal range 1..256; the counter is 8 bits wide.
- `Clock`  in  1  rising-edge clock; the only clock.
- `Resetn`  in  1  reset, asynchronous, active-low.
- `Req`  in  8  request lines; `Req[i]` high means requester `i` wants the decoder.
- `Enable`  out  1  decoder enable; high only while a grant is active.
- `A`  out  1  select MSB.
- `B`  out  1  select middle bit.
- `C`  out  1  select LSB. `{A,B,C}` is the granted index.
- `Busy`  out  1  high while the FSM is in GRANT or GAP.
- `Timeout`  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- Internal state:
  - FSM states IDLE, GRANT, GAP.
  - 3-bit `ptr` (last granted index).
  - 3-bit `idx` (current grant).
  - 8-bit hold counter `cnt`.
- Reset values: state IDLE, `ptr`=7, `idx`=0, `cnt`=0. Outputs `Enable`=0, `{A,B,C}`=000, `Busy`=0, `Timeout`=0. All outputs are registered.
- IDLE:
  - If `Req`==0, stay in IDLE.
  - Otherwise scan indices `ptr+1`, `ptr+2`, … modulo 8 (wrapping 7→0) and take the first `i` with `Req[i]`=1.
  - Set `idx`=i, `Enable`=1, `cnt`=0, and go to GRANT.
- GRANT:
  - Release: if `Req[idx]`=0, then `Enable`=0, `ptr`=idx, go to GAP.
  - Timeout (macro only): else if `cnt`==MAX_HOLD-1, then `Enable`=0, `ptr`=idx, `Timeout`=1 for one cycle, go to GAP.
  - Otherwise `cnt`=cnt+1 and stay in GRANT.
  - Changes on `Req[j]` for j≠idx are ignored while in GRANT.
- GAP: unconditionally go to IDLE. `Enable`=0.
- `{A,B,C}` holds the last `idx` in GAP and IDLE; the decoder output is zero because `Enable`=0.
- Fairness:
  - The released or revoked requester gets the lowest priority on the next scan.
  - If it is the only requester still asserting, it is granted again.
- Re-assertion: a requester that drops and re-raises `Req` during GAP is a fresh request, arbitrated normally.

## Timing
- Grant latency: `Req` sampled high in IDLE at edge k gives `Enable`=1 with a valid `{A,B,C}` after edge k.
- Release latency: `Req[idx]` sampled low at edge k gives `Enable`=0 after edge k.
- Dead time: `Enable` stays low for exactly 2 cycles between consecutive grants (GAP, then the IDLE decision edge). There is never overlap between grants.
- Timeout: a requester holding `Req` high sees `Enable` high for exactly MAX_HOLD cycles. `Timeout` is high during the first GAP cycle.
- Simultaneous release and limit in the same cycle: release wins and `Timeout` stays 0.
- `Resetn` low at any time, including mid-grant: all outputs drop to reset values immediately, without waiting for `Clock`. The first edge after deassertion resumes IDLE arbitration from index 0.

## Configuration
- `DECODER_ARB_TIMEOUT_EN`:
  - Defined: hold counter and `Timeout` are active as described above.
  - Undefined: the counter logic is omitted, a grant lasts until `Req[idx]` drops, and `Timeout` is tied to 0.

## Test plan
- Reset: `Resetn`=0 with `Req`=8'hFF → `Enable`=0, `{A,B,C}`=000, `Busy`=0, `Timeout`=0, decoder `F`=00000000.
- Single request: after reset, `Req`=00001000 → next edge `Enable`=1, `{A,B,C}`=011, `F`=00001000, `Busy`=1.
- Rotation: `Req`=10000001 held; each granted requester drops for one cycle after 3 cycles of grant.
  - Required grant order: 0, 7, 0, 7.
  - `Enable` low exactly 2 cycles between grants.
- Wrap and skip: `ptr`=5 (grant and release index 5), then `Req`=00000110 → next grant index 1, then index 2.
- Timeout (macro defined, MAX_HOLD=4): `Req`=00000100 held.
  - `Enable` high 4 cycles, then `Timeout` pulses for 1 cycle.
  - 2 low cycles, then index 2 regranted.
  - With `Req`=00010100 held instead, the second grant goes to index 4.
- Async reset mid-grant and no-macro build:
  - `Resetn` pulsed low during GRANT between edges → `Enable`=0 immediately; next grant scans from index 0.
  - Without the macro, `Req`=00000001 held 100 cycles → `Enable` stays 1 and `Timeout` stays 0.
